// File: rtl/level_sequencer_pkg.sv
// level_sequencer_pkg: shared FSM state enumeration and default game parameters
package level_sequencer_pkg;
  typedef enum logic [1:0] {S_WAIT, S_PLAY, S_OVER, S_WIN} state_e;
  localparam int DEF_NUM_LEVELS = 15;
  localparam int DEF_LIVES      = 3;
  localparam int DEF_SPEED_STEP = 1;
  localparam int DEF_SPEED_MAX  = 15;
  localparam int DEF_MAX_BLOCKS = 4;
  localparam int DEF_BLOCK_STEP = 4;
endpackage

// File: rtl/level_sequencer_sat.sv
// sat_counter: saturating up/down counter (clk, reset, clr_i reload INIT, en_i step by STEP toward LIMIT, q_o value)
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1,
  parameter int LIMIT = 15,
  parameter int INIT  = 0,
  parameter bit UP    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  logic [31:0] cur;
  always_comb begin
    cur = 32'(q_q);
    q_d = q_q;
    if (en_i) q_d = UP ? ((cur + 32'(STEP) > 32'(LIMIT)) ? WIDTH'(LIMIT) : WIDTH'(cur + 32'(STEP)))
                       : ((cur < 32'(LIMIT + STEP)) ? WIDTH'(LIMIT) : q_q - WIDTH'(STEP));
    if (clr_i) q_d = WIDTH'(INIT);
  end
  always_ff @(posedge clk) begin
    if (reset) q_q <= WIDTH'(INIT);
    else q_q <= q_d;
  end
  assign q_o = q_q;
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game level FSM (clk, reset, go, next_signal, fail in; speed, num_blocks, curr_level, lives_left, playing, level_up, game_over, win out)
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int LIVES      = DEF_LIVES,
  parameter int SPEED_STEP = DEF_SPEED_STEP,
  parameter int SPEED_MAX  = DEF_SPEED_MAX,
  parameter int MAX_BLOCKS = DEF_MAX_BLOCKS,
  parameter int BLOCK_STEP = DEF_BLOCK_STEP,
  localparam int LEVEL_W   = $clog2(NUM_LEVELS + 1),
  localparam int SPEED_W   = $clog2(SPEED_MAX + 1),
  localparam int BLOCK_W   = $clog2(MAX_BLOCKS + 1),
  localparam int LIVES_W   = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               next_signal,
  input  logic               fail,
  output logic [SPEED_W-1:0] speed,
  output logic [BLOCK_W-1:0] num_blocks,
  output logic [LEVEL_W-1:0] curr_level,
  output logic [LIVES_W-1:0] lives_left,
  output logic               playing,
  output logic               level_up,
  output logic               game_over,
  output logic               win
);
  localparam int STEP_W     = $clog2(BLOCK_STEP + 1);
  localparam int SPEED_INIT = (SPEED_STEP > SPEED_MAX) ? SPEED_MAX : SPEED_STEP;
  state_e state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic playing_q, level_up_q, game_over_q, win_q;
  logic adv, clr, step_wrap;
  assign step_wrap = step_q == STEP_W'(BLOCK_STEP - 1);
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    step_d  = step_q;
    adv     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_WAIT: state_d = go ? S_PLAY : S_WAIT;
      S_PLAY:
        if (fail) begin
          lives_d = lives_q - LIVES_W'(1);
          state_d = (lives_q == LIVES_W'(1)) ? S_OVER : S_WAIT;
        end else if (next_signal) begin
          if (level_q == LEVEL_W'(NUM_LEVELS)) state_d = S_WIN;
          else begin
            adv     = 1'b1;
            level_d = level_q + LEVEL_W'(1);
            step_d  = step_wrap ? '0 : step_q + STEP_W'(1);
            state_d = S_WAIT;
          end
        end
      default:
        if (go) begin
          clr     = 1'b1;
          state_d = S_WAIT;
          level_d = LEVEL_W'(1);
          lives_d = LIVES_W'(LIVES);
          step_d  = '0;
        end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT;
      level_q     <= LEVEL_W'(1);
      lives_q     <= LIVES_W'(LIVES);
      step_q      <= '0;
      playing_q   <= 1'b0;
      level_up_q  <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      step_q      <= step_d;
      playing_q   <= state_d == S_PLAY;
      level_up_q  <= adv;
      game_over_q <= state_d == S_OVER;
      win_q       <= state_d == S_WIN;
    end
  end
  sat_counter #(.WIDTH(SPEED_W), .STEP(SPEED_STEP), .LIMIT(SPEED_MAX), .INIT(SPEED_INIT), .UP(1'b1)) u_speed (
    .clk(clk), .reset(reset), .clr_i(clr), .en_i(adv), .q_o(speed)
  );
  sat_counter #(.WIDTH(BLOCK_W), .STEP(1), .LIMIT(1), .INIT(MAX_BLOCKS), .UP(1'b0)) u_blocks (
    .clk(clk), .reset(reset), .clr_i(clr), .en_i(adv && step_wrap), .q_o(num_blocks)
  );
  assign curr_level = level_q;
  assign lives_left = lives_q;
  assign playing    = playing_q;
  assign level_up   = level_up_q;
  assign game_over  = game_over_q;
  assign win        = win_q;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: scoreboard bench for level_sequencer at default parameters
module tb_level_sequencer;
  logic clk = 1'b0, reset = 1'b1, go = 1'b0, next_signal = 1'b0, fail = 1'b0;
  logic [3:0] speed, curr_level;
  logic [2:0] num_blocks;
  logic [1:0] lives_left;
  logic playing, level_up, game_over, win;
  level_sequencer dut (
    .clk(clk), .reset(reset), .go(go), .next_signal(next_signal), .fail(fail),
    .speed(speed), .num_blocks(num_blocks), .curr_level(curr_level), .lives_left(lives_left),
    .playing(playing), .level_up(level_up), .game_over(game_over), .win(win)
  );
  always #5 clk = ~clk;
  localparam logic [3:0] R = 4'b1000, G = 4'b0100, N = 4'b0010, F = 4'b0001, I = 4'b0000;
  int n_cmp = 0, n_mis = 0;
  logic [16:0] sb[$];
  logic [3:0] stim[$];
  logic [16:0] e;
  int m_st = 0, m_lvl = 1, m_spd = 1, m_blk = 4, m_lives = 3, m_stp = 0;
  bit m_lu = 1'b0;
  wire [16:0] obs = {curr_level, speed, num_blocks, lives_left, playing, level_up, game_over, win};
  task automatic apply(input logic [3:0] s);
    {reset, go, next_signal, fail} = s;
    if (s[3]) begin
      m_st = 0; m_lvl = 1; m_spd = 1; m_blk = 4; m_lives = 3; m_stp = 0; m_lu = 1'b0;
    end else begin
      m_lu = 1'b0;
      case (m_st)
        0: if (s[2]) m_st = 1;
        1: if (s[0]) begin
             m_lives = m_lives - 1;
             m_st = (m_lives == 0) ? 2 : 0;
           end else if (s[1]) begin
             if (m_lvl == 15) m_st = 3;
             else begin
               m_lvl = m_lvl + 1;
               m_spd = (m_spd + 1 > 15) ? 15 : m_spd + 1;
               m_stp = (m_stp + 1) % 4;
               if (m_stp == 0 && m_blk > 1) m_blk = m_blk - 1;
               m_lu = 1'b1;
               m_st = 0;
             end
           end
        default: if (s[2]) begin
             m_st = 0; m_lvl = 1; m_spd = 1; m_blk = 4; m_lives = 3; m_stp = 0;
           end
      endcase
    end
    sb.push_back({4'(m_lvl), 4'(m_spd), 3'(m_blk), 2'(m_lives), m_st == 1, m_lu, m_st == 2, m_st == 3});
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    stim = '{R, R};
    foreach (stim[i]) begin
      apply(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL reset[%0d] got %h want %h", i, obs, e); end
    end
    n_cmp++;
    if (obs !== {4'd1, 4'd1, 3'd4, 2'd3, 4'b0000}) begin
      n_mis++; $display("FAIL reset_values got %h want %h", obs, {4'd1, 4'd1, 3'd4, 2'd3, 4'b0000});
    end
  endtask
  task automatic test_start;
    apply(I);
    apply(G);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      if (i == 1) begin
        n_cmp++;
        if (obs !== e) begin n_mis++; $display("FAIL start got %h want %h", obs, e); end
      end
    end
    n_cmp++;
    if (obs !== {4'd1, 4'd1, 3'd4, 2'd3, 4'b1000}) begin
      n_mis++; $display("FAIL start_values got %h want %h", obs, {4'd1, 4'd1, 3'd4, 2'd3, 4'b1000});
    end
  endtask
  task automatic test_advance;
    int pulses = 0;
    stim.delete();
    for (int k = 0; k < 4; k++) begin stim.push_back(N); stim.push_back(G); end
    foreach (stim[i]) begin
      apply(stim[i]);
      e = sb.pop_front();
      pulses += int'(level_up);
      n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL advance[%0d] got %h want %h", i, obs, e); end
    end
    n_cmp++;
    if (pulses != 4) begin n_mis++; $display("FAIL level_up_count got %0d want 4", pulses); end
    n_cmp++;
    if ({curr_level, speed, num_blocks} !== {4'd5, 4'd5, 3'd3}) begin
      n_mis++; $display("FAIL advance_values got %h want %h", {curr_level, speed, num_blocks}, {4'd5, 4'd5, 3'd3});
    end
  endtask
  task automatic test_fail;
    stim = '{R, G, N, G, F, G, F, G, F, N, F, I, G};
    foreach (stim[i]) begin
      apply(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL fail_seq[%0d] got %h want %h", i, obs, e); end
      if (i == 8) begin
        n_cmp++;
        if ({game_over, curr_level, lives_left} !== {1'b1, 4'd2, 2'd0}) begin
          n_mis++; $display("FAIL game_over got %h want %h", {game_over, curr_level, lives_left}, {1'b1, 4'd2, 2'd0});
        end
      end
    end
    n_cmp++;
    if ({game_over, curr_level, lives_left} !== {1'b0, 4'd1, 2'd3}) begin
      n_mis++; $display("FAIL restart got %h want %h", {game_over, curr_level, lives_left}, {1'b0, 4'd1, 2'd3});
    end
  endtask
  task automatic test_both;
    stim = '{R, G, N, G, N, G, N | F};
    foreach (stim[i]) begin
      apply(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL both[%0d] got %h want %h", i, obs, e); end
    end
    n_cmp++;
    if ({lives_left, curr_level, level_up} !== {2'd2, 4'd3, 1'b0}) begin
      n_mis++; $display("FAIL both_values got %h want %h", {lives_left, curr_level, level_up}, {2'd2, 4'd3, 1'b0});
    end
  endtask
  task automatic test_win;
    int max_spd = 0;
    stim = '{R, N, F, G, G};
    for (int k = 0; k < 14; k++) begin stim.push_back(N); stim.push_back(G); end
    stim.push_back(N);
    foreach (stim[i]) begin
      apply(stim[i]);
      e = sb.pop_front();
      if (int'(speed) > max_spd) max_spd = int'(speed);
      n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL win_seq[%0d] got %h want %h", i, obs, e); end
    end
    n_cmp++;
    if ({win, curr_level, speed, num_blocks, max_spd == 15} !== {1'b1, 4'd15, 4'd15, 3'd1, 1'b1}) begin
      n_mis++; $display("FAIL win_values got %h want %h", {win, curr_level, speed, num_blocks, max_spd == 15}, {1'b1, 4'd15, 4'd15, 3'd1, 1'b1});
    end
    apply(G);
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e) begin n_mis++; $display("FAIL win_restart got %h want %h", obs, e); end
  endtask
  task automatic test_reset_mid;
    stim = '{R, G};
    for (int k = 0; k < 6; k++) begin stim.push_back(N); stim.push_back(G); end
    stim.push_back(R | G | N | F);
    foreach (stim[i]) begin
      apply(stim[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL reset_mid[%0d] got %h want %h", i, obs, e); end
    end
    n_cmp++;
    if (obs !== {4'd1, 4'd1, 3'd4, 2'd3, 4'b0000}) begin
      n_mis++; $display("FAIL reset_mid_values got %h want %h", obs, {4'd1, 4'd1, 3'd4, 2'd3, 4'b0000});
    end
  endtask
  initial begin
    test_reset;
    test_start;
    test_advance;
    test_fail;
    test_both;
    test_win;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
